// File: rtl/button_debounce_repeat.sv
// Purpose : debounce a synchronized push-button level and generate press/release
//           edge pulses plus a press + auto-repeat action pulse (btn_repeat).
// Latency : btn_level changes DEBOUNCE_CYCLES edges after a persistent input change;
//           all pulses are registered and coincide with the first cycle of the new level.
// Backpr. : none; free-running, outputs are single-cycle pulses with no handshake.
//
// Ports:
//   clk         - single clock, rising-edge
//   rst_n       - asynchronous active-low reset
//   btn_sync    - raw button level, already synchronized to clk
//   repeat_en   - 1 enables auto-repeat pulses while held
//   btn_level   - debounced button level
//   btn_press   - one-cycle pulse on accepted 0->1
//   btn_release - one-cycle pulse on accepted 1->0
//   btn_repeat  - one-cycle action pulse: press pulse plus auto-repeat pulses
module button_debounce_repeat #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_RATE     = 1250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_sync,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  RD_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  RR_LAST  = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           repeat_q, repeat_d;
  logic [1:0]     state_q, state_d;
  logic [RW-1:0]  rpt_cnt_q, rpt_cnt_d;

  // Debounce: counter runs only while the input disagrees with the accepted
  // level; the toggle happens on the edge where the count would reach
  // DEBOUNCE_CYCLES, so the counter never needs to hold that value or wrap.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (btn_sync != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end
  end

  assign press_d   =  level_d & ~level_q;
  assign release_d = ~level_d &  level_q;

  // Repeat FSM. A release takes priority over everything, including a
  // coincident counter expiry. repeat_en only masks the auto pulses; the
  // counter keeps its cadence so re-enabling stays phase-aligned to the press.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    repeat_d  = 1'b0;
    if (release_d) begin
      state_d   = S_IDLE;
      rpt_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (press_d) begin
            state_d   = S_DELAY;
            rpt_cnt_d = '0;
            repeat_d  = 1'b1;
          end
        end
        S_DELAY: begin
          if (rpt_cnt_q == RD_LAST) begin
            state_d   = S_REPEAT;
            rpt_cnt_d = '0;
            repeat_d  = repeat_en;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
          end
        end
        S_REPEAT: begin
          if (rpt_cnt_q == RR_LAST) begin
            rpt_cnt_d = '0;
            repeat_d  = repeat_en;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
          end
        end
        default: begin
          state_d   = S_IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      state_q   <= S_IDLE;
      rpt_cnt_q <= '0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Bench for button_debounce_repeat with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Directed scenarios plus a randomized run checked against a timestamp-based
// reference: debounce from the last N samples, repeat pulses from time since press.
module tb_button_debounce_repeat;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn_sync = 1'b0;
  logic repeat_en = 1'b1;
  logic btn_level, btn_press, btn_release, btn_repeat;
  logic [3:0] obs;

  int checks = 0;
  int failures = 0;

  button_debounce_repeat #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_sync(btn_sync),
    .repeat_en(repeat_en),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  assign obs = {btn_level, btn_press, btn_release, btn_repeat};

  // ---------------- reference model ----------------
  int   hist[$];
  bit   m_level;
  int   press_t;
  int   t;
  logic [3:0] exp_v;

  task automatic model_reset();
    hist.delete();
    m_level = 1'b0;
    press_t = -1;
    exp_v   = 4'b0000;
  endtask

  // Advance one rising edge, update the model from the inputs seen at that edge,
  // and return #1 later so outputs can be sampled.
  task automatic tick();
    bit acc, rose, fell, auto_p;
    int d;
    @(posedge clk);
    t++;
    hist.push_back(int'(btn_sync));
    if (hist.size() > DB) void'(hist.pop_front());
    acc = (hist.size() == DB);
    foreach (hist[k]) if (hist[k] == int'(m_level)) acc = 1'b0;
    rose = 1'b0;
    fell = 1'b0;
    if (acc) begin
      m_level = !m_level;
      hist.delete();
      rose = m_level;
      fell = !m_level;
    end
    if (rose) press_t = t;
    if (fell) press_t = -1;
    d = t - press_t;
    auto_p = m_level && press_t >= 0 && d >= RD && ((d - RD) % RR) == 0 && repeat_en;
    exp_v = {m_level, rose, fell, rose | auto_p};
    #1;
  endtask

  task automatic start_fresh();
    rst_n = 1'b0;
    btn_sync = 1'b0;
    repeat_en = 1'b1;
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000", obs);
    end
    checks++;
    if (dut.db_cnt_q !== '0 || dut.rpt_cnt_q !== '0 || dut.state_q !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got db=%0d rpt=%0d st=%0d want 0/0/0",
               dut.db_cnt_q, dut.rpt_cnt_q, dut.state_q);
    end
    model_reset();
  endtask

  task automatic test_clean_press();
    bit want_rep;
    start_fresh();
    btn_sync = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL clean_model e=%0d got=%b want=%b", e, obs, exp_v);
      end
      want_rep = (e == 4 || e == 14 || e == 17 || e == 20);
      checks++;
      if (btn_repeat !== want_rep || btn_press !== (e == 4) || btn_level !== (e >= 4)) begin
        failures++;
        $display("FAIL clean_directed e=%0d got lvl=%b prs=%b rep=%b want lvl=%b prs=%b rep=%b",
                 e, btn_level, btn_press, btn_repeat, e >= 4, e == 4, want_rep);
      end
    end
  endtask

  task automatic test_glitch();
    start_fresh();
    btn_sync = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      if (e == 4) btn_sync = 1'b0;
      tick();
      checks++;
      if (obs !== 4'b0000 || obs !== exp_v) begin
        failures++;
        $display("FAIL glitch e=%0d got=%b want=0000", e, obs);
      end
    end
    checks++;
    if (dut.db_cnt_q !== '0) begin
      failures++;
      $display("FAIL glitch_dbcnt got=%0d want=0", dut.db_cnt_q);
    end
  endtask

  task automatic test_release();
    start_fresh();
    btn_sync = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      if (e == 17) btn_sync = 1'b0;
      tick();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL release_model e=%0d got=%b want=%b", e, obs, exp_v);
      end
    end
    checks++;
    if (obs !== 4'b0010 || dut.state_q !== 2'd0 || dut.rpt_cnt_q !== '0) begin
      failures++;
      $display("FAIL release_edge20 got=%b st=%0d rpt=%0d want=0010 st=0 rpt=0",
               obs, dut.state_q, dut.rpt_cnt_q);
    end
  endtask

  task automatic test_repeat_disable();
    int nrep;
    start_fresh();
    repeat_en = 1'b0;
    btn_sync = 1'b1;
    nrep = 0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (btn_repeat === 1'b1) nrep++;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL rptdis_model e=%0d got=%b want=%b", e, obs, exp_v);
      end
    end
    checks++;
    if (nrep !== 1) begin
      failures++;
      $display("FAIL rptdis_count got=%0d want=1", nrep);
    end
  endtask

  task automatic test_reset_mid();
    start_fresh();
    btn_sync = 1'b1;
    for (int e = 1; e <= 15; e++) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 4'b0000 || dut.state_q !== 2'd0 || dut.rpt_cnt_q !== '0) begin
      failures++;
      $display("FAIL midreset_async got=%b st=%0d want=0000 st=0", obs, dut.state_q);
    end
    model_reset();
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (btn_press !== (e == 4) || btn_release !== 1'b0 || obs !== exp_v) begin
        failures++;
        $display("FAIL midreset_repress e=%0d got=%b want=%b", e, obs, exp_v);
      end
    end
    // Abort while held, then let go: no release may be reported.
    #2 rst_n = 1'b0;
    btn_sync = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (obs !== 4'b0000) begin
        failures++;
        $display("FAIL midreset_norelease e=%0d got=%b want=0000", e, obs);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    logic [2:0] prev;
    start_fresh();
    hold = 0;
    prev = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        btn_sync = 1'($urandom_range(0, 1));
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
      end
      hold--;
      if ($urandom_range(0, 15) == 0) repeat_en = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL random_model c=%0d got=%b want=%b", c, obs, exp_v);
      end
      checks++;
      if ((prev & {btn_press, btn_release, btn_repeat}) !== 3'b000) begin
        failures++;
        $display("FAIL random_pulsewidth c=%0d got prev=%b now=%b want no overlap",
                 c, prev, {btn_press, btn_release, btn_repeat});
      end
      prev = {btn_press, btn_release, btn_repeat};
    end
  endtask

  initial begin
    t = 0;
    model_reset();
    test_reset();
    test_clean_press();
    test_glitch();
    test_release();
    test_repeat_disable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
